// File: rtl/divider_pkg.sv
// Shared state encoding and mode selectors for the WIDTH-bit divider core.
package divider_pkg;

    // One-hot so each bit can drive its state LED directly.
    typedef enum logic [2:0] {
        QI = 3'b001,
        QC = 3'b010,
        QD = 3'b100
    } state_t;

    localparam int MODE_REPSUB   = 0;
    localparam int MODE_SHIFTSUB = 1;

endpackage

// File: rtl/divider_n_step.sv
// Combinational compare/subtract on WIDTH+1-bit operands, shared by both divide modes.
module divider_n_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic           ge,
    output logic [WIDTH:0] diff
);

    assign ge   = (a >= b);
    assign diff = a - b;

endmodule

// File: rtl/divider_n_core.sv
// Unsigned WIDTH-bit divider with Start/Ack handshake; MODE picks repetitive
// subtraction (quotient+1 clocks) or restoring shift-subtract (WIDTH clocks).
module divider_n_core
    import divider_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] Xin,
    input  logic [WIDTH-1:0] Yin,
    input  logic             Start,
    input  logic             Ack,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Done,
    output logic             DivByZero,
    output logic             Qi,
    output logic             Qc,
    output logic             Qd
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_reg;
    logic [WIDTH-1:0] x_reg, y_reg, r_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             dbz_reg;
    logic [CW-1:0]    count_reg;

    logic [WIDTH:0]   step_a, step_b, step_diff;
    logic             step_ge;
    logic [WIDTH-1:0] x_next, r_next, q_next, rem_next;
    logic [CW-1:0]    count_next;
    logic             finish;

    assign step_b = {1'b0, y_reg};

    divider_n_step #(.WIDTH(WIDTH)) u_step (
        .a    (step_a),
        .b    (step_b),
        .ge   (step_ge),
        .diff (step_diff)
    );

    generate
        if (MODE == MODE_SHIFTSUB) begin : g_shiftsub
            // r_reg is the partial remainder; x_reg shifts the dividend out MSB first.
            assign step_a = {r_reg, x_reg[WIDTH-1]};

            always_comb begin
                x_next     = {x_reg[WIDTH-2:0], 1'b0};
                r_next     = step_ge ? step_diff[WIDTH-1:0] : step_a[WIDTH-1:0];
                q_next     = {quotient_reg[WIDTH-2:0], step_ge};
                rem_next   = r_next;
                count_next = count_reg + 1'b1;
                finish     = (count_reg == CW'(WIDTH - 1));
                if (y_reg == '0) begin
                    q_next   = '1;
                    rem_next = x_reg;
                    finish   = 1'b1;
                end
            end
        end else begin : g_repsub
            // r_reg is the running dividend, reduced by Y once per clock.
            assign step_a = {1'b0, r_reg};

            always_comb begin
                x_next     = x_reg;
                r_next     = r_reg;
                q_next     = quotient_reg;
                rem_next   = remainder_reg;
                count_next = count_reg;
                finish     = 1'b0;
                if (y_reg == '0) begin
                    q_next   = '1;
                    rem_next = x_reg;
                    finish   = 1'b1;
                end else if (step_ge) begin
                    r_next = step_diff[WIDTH-1:0];
                    q_next = quotient_reg + 1'b1;
                end else begin
                    rem_next = r_reg;
                    finish   = 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_reg     <= QI;
            x_reg         <= '0;
            y_reg         <= '0;
            r_reg         <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            count_reg     <= '0;
        end else begin
            case (state_reg)
                QI: begin
                    if (Start) begin
                        x_reg        <= Xin;
                        y_reg        <= Yin;
                        r_reg        <= (MODE == MODE_SHIFTSUB) ? '0 : Xin;
                        quotient_reg <= '0;
                        dbz_reg      <= (Yin == '0);
                        count_reg    <= '0;
                        state_reg    <= QC;
                    end
                end
                QC: begin
                    x_reg         <= x_next;
                    r_reg         <= r_next;
                    quotient_reg  <= q_next;
                    remainder_reg <= rem_next;
                    count_reg     <= count_next;
                    if (finish) begin
                        state_reg <= QD;
                    end
                end
                QD: begin
                    if (Ack) begin
                        state_reg <= QI;
                    end
                end
                default: state_reg <= QI;
            endcase
        end
    end

    assign Quotient  = quotient_reg;
    assign Remainder = remainder_reg;
    assign DivByZero = dbz_reg;
    assign Qi        = (state_reg == QI);
    assign Qc        = (state_reg == QC);
    assign Qd        = (state_reg == QD);
    assign Done      = Qd;

endmodule

// File: tb/tb_divider_n_core.sv
// Directed/table-driven bench for divider_n_core: W=4 MODE=0 plus W=8 in both modes side by side.
module tb_divider_n_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] xin, yin;
    logic       start, ack;
    logic [3:0] xin4, yin4;
    logic       start4, ack4;

    logic [7:0] q80, r80, q81, r81;
    logic       done80, dbz80, qi80, qc80, qd80;
    logic       done81, dbz81, qi81, qc81, qd81;
    logic [3:0] q4, r4;
    logic       done4, dbz4, qi4, qc4, qd4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divider_n_core #(.WIDTH(8), .MODE(0)) u_rep8 (
        .Clk(clk), .Reset_n(reset_n), .Xin(xin), .Yin(yin), .Start(start), .Ack(ack),
        .Quotient(q80), .Remainder(r80), .Done(done80), .DivByZero(dbz80),
        .Qi(qi80), .Qc(qc80), .Qd(qd80)
    );

    divider_n_core #(.WIDTH(8), .MODE(1)) u_shift8 (
        .Clk(clk), .Reset_n(reset_n), .Xin(xin), .Yin(yin), .Start(start), .Ack(ack),
        .Quotient(q81), .Remainder(r81), .Done(done81), .DivByZero(dbz81),
        .Qi(qi81), .Qc(qc81), .Qd(qd81)
    );

    divider_n_core #(.WIDTH(4), .MODE(0)) u_rep4 (
        .Clk(clk), .Reset_n(reset_n), .Xin(xin4), .Yin(yin4), .Start(start4), .Ack(ack4),
        .Quotient(q4), .Remainder(r4), .Done(done4), .DivByZero(dbz4),
        .Qi(qi4), .Qc(qc4), .Qd(qd4)
    );

    typedef struct {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] q;
        logic [7:0] r;
        int         cyc_rep;
        int         cyc_shift;
    } vec_t;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] q;
        logic [3:0] r;
        int         cyc;
        logic       dbz;
    } vec4_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic start8(input logic [7:0] x, input logic [7:0] y);
        xin   = x;
        yin   = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic finish8(output int c0, output int c1);
        bit ok;
        c0 = 0;
        c1 = 0;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (qc80) c0++;
            if (qc81) c1++;
            if (qd80 && qd81) ok = 1'b1;
            else tick();
        end
        check("done_timeout8", 32'(ok), 32'd1);
    endtask

    task automatic results8(input logic [7:0] eq, input logic [7:0] er, input logic edbz);
        check("q_rep8", 32'(q80), 32'(eq));
        check("r_rep8", 32'(r80), 32'(er));
        check("q_shift8", 32'(q81), 32'(eq));
        check("r_shift8", 32'(r81), 32'(er));
        check("dbz_rep8", 32'(dbz80), 32'(edbz));
        check("dbz_shift8", 32'(dbz81), 32'(edbz));
        check("done_rep8", 32'(done80), 32'd1);
        check("done_shift8", 32'(done81), 32'd1);
    endtask

    task automatic ack8();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_qi_rep8", 32'(qi80), 32'd1);
        check("ack_qi_shift8", 32'(qi81), 32'd1);
    endtask

    task automatic run8(input vec_t v, input bit do_ack);
        int c0, c1;
        start8(v.x, v.y);
        finish8(c0, c1);
        results8(v.q, v.r, v.y == 8'd0);
        check("cycles_rep8", 32'(c0), 32'(v.cyc_rep));
        check("cycles_shift8", 32'(c1), 32'(v.cyc_shift));
        $display("div8 x=%0d y=%0d rep q=%0d r=%0d clk=%0d shift q=%0d r=%0d clk=%0d",
                 v.x, v.y, q80, r80, c0, q81, r81, c1);
        if (do_ack) ack8();
    endtask

    task automatic run4(input vec4_t v);
        int  c;
        bit  ok;
        xin4   = v.x;
        yin4   = v.y;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        c  = 0;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (qc4) c++;
            if (qd4) ok = 1'b1;
            else tick();
        end
        check("done_timeout4", 32'(ok), 32'd1);
        check("q_rep4", 32'(q4), 32'(v.q));
        check("r_rep4", 32'(r4), 32'(v.r));
        check("dbz_rep4", 32'(dbz4), 32'(v.dbz));
        check("done_rep4", 32'(done4), 32'd1);
        check("cycles_rep4", 32'(c), 32'(v.cyc));
        $display("div4 x=%0d y=%0d q=%0d r=%0d clk=%0d", v.x, v.y, q4, r4, c);
        ack4 = 1'b1;
        tick();
        ack4 = 1'b0;
        check("ack_qi_rep4", 32'(qi4), 32'd1);
    endtask

    function automatic vec_t model8(input logic [7:0] x, input logic [7:0] y);
        vec_t v;
        v.x = x;
        v.y = y;
        if (y == 8'd0) begin
            v.q = 8'hFF;
            v.r = x;
            v.cyc_rep   = 1;
            v.cyc_shift = 1;
        end else begin
            v.q = x / y;
            v.r = x % y;
            v.cyc_rep   = int'(x / y) + 1;
            v.cyc_shift = 8;
        end
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[9];
        vec4_t vecs4[4];
        int    c0, c1;

        vecs[0] = '{8'd200, 8'd7,   8'd28,  8'd4,  29,  8};
        vecs[1] = '{8'd9,   8'd0,   8'd255, 8'd9,  1,   1};
        vecs[2] = '{8'd3,   8'd5,   8'd0,   8'd3,  1,   8};
        vecs[3] = '{8'd255, 8'd1,   8'd255, 8'd0,  256, 8};
        vecs[4] = '{8'd0,   8'd1,   8'd0,   8'd0,  1,   8};
        vecs[5] = '{8'd255, 8'd255, 8'd1,   8'd0,  2,   8};
        vecs[6] = '{8'd100, 8'd10,  8'd10,  8'd0,  11,  8};
        vecs[7] = '{8'd17,  8'd255, 8'd0,   8'd17, 1,   8};
        vecs[8] = '{8'd128, 8'd3,   8'd42,  8'd2,  43,  8};

        vecs4[0] = '{4'd13, 4'd4, 4'd3,  4'd1,  4,  1'b0};
        vecs4[1] = '{4'd9,  4'd0, 4'd15, 4'd9,  1,  1'b1};
        vecs4[2] = '{4'd15, 4'd1, 4'd15, 4'd0,  16, 1'b0};
        vecs4[3] = '{4'd2,  4'd3, 4'd0,  4'd2,  1,  1'b0};

        reset_n = 1'b0;
        xin = '0; yin = '0; start = 1'b0; ack = 1'b0;
        xin4 = '0; yin4 = '0; start4 = 1'b0; ack4 = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state
        check("rst_qi_rep8", 32'(qi80), 32'd1);
        check("rst_qi_shift8", 32'(qi81), 32'd1);
        check("rst_qi_rep4", 32'(qi4), 32'd1);
        check("rst_done_rep8", 32'(done80), 32'd0);
        check("rst_q_shift8", 32'(q81), 32'd0);
        check("rst_r_rep8", 32'(r80), 32'd0);
        check("rst_dbz_shift8", 32'(dbz81), 32'd0);

        for (int i = 0; i < 4; i++) run4(vecs4[i]);
        for (int i = 0; i < 9; i++) run8(vecs[i], 1'b1);

        // Results and Done hold while Ack stays low
        run8(vecs[0], 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_q_shift8", 32'(q81), 32'd28);
            check("hold_r_shift8", 32'(r81), 32'd4);
            check("hold_done_shift8", 32'(done81), 32'd1);
            check("hold_q_rep8", 32'(q80), 32'd28);
            check("hold_done_rep8", 32'(done80), 32'd1);
        end
        ack8();

        // Divide-by-zero flag survives Ack until the next Start
        run8(vecs[1], 1'b1);
        tick();
        tick();
        check("dbz_hold_rep8", 32'(dbz80), 32'd1);
        check("dbz_hold_shift8", 32'(dbz81), 32'd1);
        check("dbz_hold_q_shift8", 32'(q81), 32'd255);
        start8(8'd9, 8'd3);
        check("dbz_clear_rep8", 32'(dbz80), 32'd0);
        check("dbz_clear_shift8", 32'(dbz81), 32'd0);
        finish8(c0, c1);
        results8(8'd3, 8'd0, 1'b0);
        ack8();

        // Reset mid-QC
        run8(vecs[8], 1'b1);
        start8(8'd200, 8'd7);
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midrst_qi_rep8", 32'(qi80), 32'd1);
        check("midrst_qi_shift8", 32'(qi81), 32'd1);
        check("midrst_q_rep8", 32'(q80), 32'd0);
        check("midrst_r_rep8", 32'(r80), 32'd0);
        check("midrst_q_shift8", 32'(q81), 32'd0);
        check("midrst_r_shift8", 32'(r81), 32'd0);
        check("midrst_done_rep8", 32'(done80), 32'd0);
        run8(vecs[0], 1'b1);

        // Reset in QD clears the divide-by-zero flag
        run8(vecs[1], 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("qdrst_dbz_rep8", 32'(dbz80), 32'd0);
        check("qdrst_dbz_shift8", 32'(dbz81), 32'd0);
        check("qdrst_q_rep8", 32'(q80), 32'd0);
        check("qdrst_r_shift8", 32'(r81), 32'd0);
        check("qdrst_qi_shift8", 32'(qi81), 32'd1);

        // Start+Ack in QD: Ack wins, held Start re-triggers next clock
        run8(model8(8'd30, 8'd4), 1'b0);
        xin   = 8'd50;
        yin   = 8'd5;
        start = 1'b1;
        ack   = 1'b1;
        tick();
        ack = 1'b0;
        check("ackwins_qi_rep8", 32'(qi80), 32'd1);
        check("ackwins_qi_shift8", 32'(qi81), 32'd1);
        tick();
        start = 1'b0;
        check("retrig_qc_rep8", 32'(qc80), 32'd1);
        check("retrig_qc_shift8", 32'(qc81), 32'd1);
        xin = 8'd200;
        yin = 8'd0;
        tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ackqc_qc_rep8", 32'(qc80), 32'd1);
        check("ackqc_qc_shift8", 32'(qc81), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("startqc_qc_rep8", 32'(qc80), 32'd1);
        finish8(c0, c1);
        results8(8'd10, 8'd0, 1'b0);
        $display("div8 x=50 y=5 with interference rep q=%0d shift q=%0d", q80, q81);
        ack8();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ackqi_qi_rep8", 32'(qi80), 32'd1);
        check("ackqi_q_shift8", 32'(q81), 32'd10);

        // Random operands against the bench's own division model
        for (int i = 0; i < 12; i++) begin
            logic [7:0] rx, ry;
            rx = 8'($urandom_range(0, 255));
            ry = (i % 6 == 5) ? 8'd0 : 8'($urandom_range(1, 255));
            run8(model8(rx, ry), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
